// File: rtl/id_issue_stage_pkg.sv
// Shared constants and types for the decode/issue stage: ALU function codes,
// RV32I opcode/funct constants, operand-select enums and the decoder bundle.
package id_issue_stage_pkg;

    // ALU function codes consumed by EX
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_JALR = 4'd10;
    localparam logic [3:0] ALU_X    = 4'd15;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 for OP/OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 value selecting SUB / SRA / SRAI
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} src1_sel_e;
    typedef enum logic [1:0] {SRC2_RS2, SRC2_IMM, SRC2_FOUR, SRC2_ZERO} src2_sel_e;

    typedef struct packed {
        logic [3:0]  fn;
        src1_sel_e   src1_sel;
        src2_sel_e   src2_sel;
        logic [31:0] imm;
        logic        wb_en;
        logic        mem_ren;
        logic        mem_wen;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic        uses_rs1;
        logic        uses_rs2;
    } dec_t;

    // Map funct3 (+ alternate bit, already qualified by the caller) to an ALU code
    function automatic logic [3:0] alu_fn_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] fn;
        case (f3)
            F3_ADD_SUB: fn = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     fn = ALU_SLL;
            F3_SLT:     fn = ALU_SLT;
            F3_SLTU:    fn = ALU_SLTU;
            F3_XOR:     fn = ALU_XOR;
            F3_SRL_SRA: fn = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      fn = ALU_OR;
            F3_AND:     fn = ALU_AND;
            default:    fn = ALU_X;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/id_issue_stage_decoder.sv
// Purely combinational RV32I decoder: function code, operand selects,
// immediate, control flags and which source registers are actually read.
module id_issue_stage_decoder
    import id_issue_stage_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    dec_t        w_dec;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_u  = {i_inst[31:12], 12'h000};

    // Decode the opcode; anything unrecognised stays flagged illegal with no side effects
    always_comb begin
        w_dec          = '0;
        w_dec.fn       = ALU_X;
        w_dec.src1_sel = SRC1_ZERO;
        w_dec.src2_sel = SRC2_ZERO;
        w_dec.illegal  = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                w_dec.fn       = alu_fn_from_f3(w_f3, i_inst[31:25] == F7_ALT);
                w_dec.src1_sel = SRC1_RS1;
                w_dec.src2_sel = SRC2_RS2;
                w_dec.wb_en    = 1'b1;
                w_dec.uses_rs1 = 1'b1;
                w_dec.uses_rs2 = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            OPC_OPIMM: begin
                // funct7 only matters for the right shifts; SUB is never produced
                w_dec.fn       = alu_fn_from_f3(w_f3,
                                    (w_f3 == F3_SRL_SRA) && (i_inst[31:25] == F7_ALT));
                w_dec.src1_sel = SRC1_RS1;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.imm      = w_imm_i;
                w_dec.wb_en    = 1'b1;
                w_dec.uses_rs1 = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            OPC_LUI: begin
                w_dec.fn       = ALU_ADD;
                w_dec.src1_sel = SRC1_ZERO;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.imm      = w_imm_u;
                w_dec.wb_en    = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            OPC_AUIPC: begin
                w_dec.fn       = ALU_ADD;
                w_dec.src1_sel = SRC1_PC;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.imm      = w_imm_u;
                w_dec.wb_en    = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            OPC_JAL: begin
                // ALU computes the link value pc+4
                w_dec.fn       = ALU_ADD;
                w_dec.src1_sel = SRC1_PC;
                w_dec.src2_sel = SRC2_FOUR;
                w_dec.wb_en    = 1'b1;
                w_dec.jump     = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            OPC_JALR: begin
                // ALU computes the target; EX builds the link from pc+4
                w_dec.fn       = ALU_JALR;
                w_dec.src1_sel = SRC1_RS1;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.imm      = w_imm_i;
                w_dec.wb_en    = 1'b1;
                w_dec.jump     = 1'b1;
                w_dec.uses_rs1 = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    F3_BEQ, F3_BNE:   w_dec.fn = ALU_SUB;
                    F3_BLT, F3_BGE:   w_dec.fn = ALU_SLT;
                    F3_BLTU, F3_BGEU: w_dec.fn = ALU_SLTU;
                    default:          w_dec.fn = ALU_X;
                endcase
                if (w_dec.fn != ALU_X) begin
                    w_dec.src1_sel = SRC1_RS1;
                    w_dec.src2_sel = SRC2_RS2;
                    w_dec.branch   = 1'b1;
                    w_dec.uses_rs1 = 1'b1;
                    w_dec.uses_rs2 = 1'b1;
                    w_dec.illegal  = 1'b0;
                end else begin
                    w_dec.illegal  = 1'b1;
                end
            end
            OPC_LOAD: begin
                w_dec.fn       = ALU_ADD;
                w_dec.src1_sel = SRC1_RS1;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.imm      = w_imm_i;
                w_dec.mem_ren  = 1'b1;
                w_dec.wb_en    = 1'b1;
                w_dec.uses_rs1 = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            OPC_STORE: begin
                w_dec.fn       = ALU_ADD;
                w_dec.src1_sel = SRC1_RS1;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.imm      = w_imm_s;
                w_dec.mem_wen  = 1'b1;
                w_dec.uses_rs1 = 1'b1;
                w_dec.uses_rs2 = 1'b1;
                w_dec.illegal  = 1'b0;
            end
            default: begin
                w_dec.illegal  = 1'b1;
            end
        endcase
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: valid/ready intake from fetch, register-file read,
// operand selection, load-use interlock and a single output register toward EX.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 5
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [DATA_LEN-1:0] in_pc,
    output logic [ADDR_LEN-1:0] rs1_addr,
    output logic [ADDR_LEN-1:0] rs2_addr,
    input  logic [DATA_LEN-1:0] rs1_data,
    input  logic [DATA_LEN-1:0] rs2_data,
    input  logic                ld_valid,
    input  logic [ADDR_LEN-1:0] ld_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_alu_fn,
    output logic [DATA_LEN-1:0] out_src1,
    output logic [DATA_LEN-1:0] out_src2,
    output logic [DATA_LEN-1:0] out_rs2,
    output logic [DATA_LEN-1:0] out_pc,
    output logic [ADDR_LEN-1:0] out_rd,
    output logic [2:0]          out_funct3,
    output logic                out_wb_en,
    output logic                out_mem_ren,
    output logic                out_mem_wen,
    output logic                out_branch,
    output logic                out_jump,
    output logic                out_illegal
);

    dec_t                w_dec;
    logic                w_adv;
    logic                w_hazard;
    logic [ADDR_LEN-1:0] w_rd;
    logic [DATA_LEN-1:0] w_rs1_val;
    logic [DATA_LEN-1:0] w_rs2_val;
    logic [DATA_LEN-1:0] w_imm;
    logic [DATA_LEN-1:0] w_src1;
    logic [DATA_LEN-1:0] w_src2;

    logic                r_out_valid;
    logic [3:0]          r_alu_fn;
    logic [DATA_LEN-1:0] r_src1;
    logic [DATA_LEN-1:0] r_src2;
    logic [DATA_LEN-1:0] r_rs2;
    logic [DATA_LEN-1:0] r_pc;
    logic [ADDR_LEN-1:0] r_rd;
    logic [2:0]          r_funct3;
    logic                r_wb_en;
    logic                r_mem_ren;
    logic                r_mem_wen;
    logic                r_branch;
    logic                r_jump;
    logic                r_illegal;

    id_issue_stage_decoder u_dec (
        .i_inst (in_inst),
        .o_dec  (w_dec)
    );

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];
    assign w_rd     = in_inst[11:7];

    // x0 always reads as zero; nothing is forwarded here
    assign w_rs1_val = (rs1_addr == {ADDR_LEN{1'b0}}) ? {DATA_LEN{1'b0}} : rs1_data;
    assign w_rs2_val = (rs2_addr == {ADDR_LEN{1'b0}}) ? {DATA_LEN{1'b0}} : rs2_data;
    assign w_imm     = DATA_LEN'(signed'(w_dec.imm));

    assign w_adv    = !r_out_valid || out_ready;
    assign w_hazard = in_valid && ld_valid && (ld_rd != {ADDR_LEN{1'b0}}) &&
                      ((w_dec.uses_rs1 && (rs1_addr == ld_rd)) ||
                       (w_dec.uses_rs2 && (rs2_addr == ld_rd)));
    assign in_ready = w_adv && !w_hazard && !flush;

    // Operand muxes driven by the decoder's select codes
    always_comb begin
        w_src1 = {DATA_LEN{1'b0}};
        w_src2 = {DATA_LEN{1'b0}};
        case (w_dec.src1_sel)
            SRC1_RS1:  w_src1 = w_rs1_val;
            SRC1_PC:   w_src1 = in_pc;
            SRC1_ZERO: w_src1 = {DATA_LEN{1'b0}};
            default:   w_src1 = {DATA_LEN{1'b0}};
        endcase
        case (w_dec.src2_sel)
            SRC2_RS2:  w_src2 = w_rs2_val;
            SRC2_IMM:  w_src2 = w_imm;
            SRC2_FOUR: w_src2 = {{(DATA_LEN-3){1'b0}}, 3'd4};
            SRC2_ZERO: w_src2 = {DATA_LEN{1'b0}};
            default:   w_src2 = {DATA_LEN{1'b0}};
        endcase
    end

    // Output register: reset > flush > bubble on hazard > capture > drain > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_alu_fn    <= 4'd0;
            r_src1      <= {DATA_LEN{1'b0}};
            r_src2      <= {DATA_LEN{1'b0}};
            r_rs2       <= {DATA_LEN{1'b0}};
            r_pc        <= {DATA_LEN{1'b0}};
            r_rd        <= {ADDR_LEN{1'b0}};
            r_funct3    <= 3'd0;
            r_wb_en     <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_adv && w_hazard) begin
            r_out_valid <= 1'b0;
        end else if (w_adv && in_valid) begin
            r_out_valid <= 1'b1;
            r_alu_fn    <= w_dec.fn;
            r_src1      <= w_src1;
            r_src2      <= w_src2;
            r_rs2       <= w_rs2_val;
            r_pc        <= in_pc;
            r_rd        <= w_rd;
            r_funct3    <= in_inst[14:12];
            r_wb_en     <= w_dec.wb_en && (w_rd != {ADDR_LEN{1'b0}});
            r_mem_ren   <= w_dec.mem_ren;
            r_mem_wen   <= w_dec.mem_wen;
            r_branch    <= w_dec.branch;
            r_jump      <= w_dec.jump;
            r_illegal   <= w_dec.illegal;
        end else if (w_adv) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_alu_fn  = r_alu_fn;
    assign out_src1    = r_src1;
    assign out_src2    = r_src2;
    assign out_rs2     = r_rs2;
    assign out_pc      = r_pc;
    assign out_rd      = r_rd;
    assign out_funct3  = r_funct3;
    assign out_wb_en   = r_wb_en;
    assign out_mem_ren = r_mem_ren;
    assign out_mem_wen = r_mem_wen;
    assign out_branch  = r_branch;
    assign out_jump    = r_jump;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: a table of single-instruction vectors
// plus hand-written sequences for reset, load-use, back-pressure and flush.
module tb_id_issue_stage;
    import id_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, ld_valid, out_ready;
    logic [31:0] in_inst, in_pc, rs1_data, rs2_data;
    logic [4:0]  ld_rd;
    logic        in_ready, out_valid;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    logic [3:0]  out_alu_fn;
    logic [31:0] out_src1, out_src2, out_rs2, out_pc;
    logic [2:0]  out_funct3;
    logic        out_wb_en, out_mem_ren, out_mem_wen, out_branch, out_jump, out_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    id_issue_stage #(.DATA_LEN(32), .ADDR_LEN(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_fn(out_alu_fn),
        .out_src1(out_src1), .out_src2(out_src2), .out_rs2(out_rs2), .out_pc(out_pc),
        .out_rd(out_rd), .out_funct3(out_funct3), .out_wb_en(out_wb_en),
        .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_branch(out_branch),
        .out_jump(out_jump), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // flags order: {wb_en, mem_ren, mem_wen, branch, jump, illegal}
    localparam logic [5:0] FL_WB  = 6'b100000;
    localparam logic [5:0] FL_REN = 6'b010000;
    localparam logic [5:0] FL_WEN = 6'b001000;
    localparam logic [5:0] FL_BR  = 6'b000100;
    localparam logic [5:0] FL_JMP = 6'b000010;
    localparam logic [5:0] FL_ILL = 6'b000001;

    typedef struct {
        logic [31:0] inst, pc, rs1d, rs2d;
        logic [3:0]  fn;
        logic [31:0] src1, src2, rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [5:0]  flags;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] inst, pc, rs1d, rs2d,
                                input logic [3:0] fn, input logic [31:0] s1, s2, r2,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic [5:0] fl);
        vec_t v;
        v.inst = inst; v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d;
        v.fn = fn; v.src1 = s1; v.src2 = s2; v.rs2 = r2;
        v.rd = rd; v.f3 = f3; v.flags = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] inst, pc, r1, r2);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
    endtask

    function automatic logic [5:0] act_flags();
        return {out_wb_en, out_mem_ren, out_mem_wen, out_branch, out_jump, out_illegal};
    endfunction

    initial begin
        vecs[0]  = mk(32'hFFD08293, 32'h100, 32'd10, 32'h55, ALU_ADD, 32'd10, 32'hFFFFFFFD, 32'h55, 5'd5, 3'd0, FL_WB);
        vecs[1]  = mk(32'h4041D113, 32'h104, 32'h80000000, 32'h66, ALU_SRA, 32'h80000000, 32'h404, 32'h66, 5'd2, 3'd5, FL_WB);
        vecs[2]  = mk(32'h403100B3, 32'h108, 32'd100, 32'd30, ALU_SUB, 32'd100, 32'd30, 32'd30, 5'd1, 3'd0, FL_WB);
        vecs[3]  = mk(32'h123453B7, 32'h10C, 32'hDEAD, 32'h77, ALU_ADD, 32'h0, 32'h12345000, 32'h77, 5'd7, 3'd5, FL_WB);
        vecs[4]  = mk(32'h00001197, 32'h110, 32'h88, 32'h99, ALU_ADD, 32'h110, 32'h1000, 32'h0, 5'd3, 3'd1, FL_WB);
        vecs[5]  = mk(32'h008000EF, 32'h114, 32'h11, 32'h12, ALU_ADD, 32'h114, 32'd4, 32'h12, 5'd1, 3'd0, FL_WB | FL_JMP);
        vecs[6]  = mk(32'h00008067, 32'h118, 32'h2000, 32'h34, ALU_JALR, 32'h2000, 32'h0, 32'h0, 5'd0, 3'd0, FL_JMP);
        vecs[7]  = mk(32'h00208463, 32'h11C, 32'd5, 32'd5, ALU_SUB, 32'd5, 32'd5, 32'd5, 5'd8, 3'd0, FL_BR);
        vecs[8]  = mk(32'h0020E463, 32'h120, 32'd1, 32'd2, ALU_SLTU, 32'd1, 32'd2, 32'd2, 5'd8, 3'd6, FL_BR);
        vecs[9]  = mk(32'h00812203, 32'h124, 32'h1000, 32'h44, ALU_ADD, 32'h1000, 32'd8, 32'h44, 5'd4, 3'd2, FL_WB | FL_REN);
        vecs[10] = mk(32'h00532623, 32'h128, 32'h2000, 32'hCAFEBABE, ALU_ADD, 32'h2000, 32'd12, 32'hCAFEBABE, 5'd12, 3'd2, FL_WEN);
        vecs[11] = mk(32'h0000007F, 32'h12C, 32'd1, 32'd1, ALU_X, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, FL_ILL);
        vecs[12] = mk(32'h00728333, 32'h130, 32'd3, 32'd4, ALU_ADD, 32'd3, 32'd4, 32'd4, 5'd6, 3'd0, FL_WB);
        vecs[13] = mk(32'h002064B3, 32'h134, 32'hFFFF, 32'hF0, ALU_OR, 32'h0, 32'hF0, 32'hF0, 5'd9, 3'd6, FL_WB);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; ld_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'hFFD08293; in_pc = 32'h40; rs1_data = 32'd7; rs2_data = 32'd7; ld_rd = 5'd0;

        // Reset: everything cleared even with an instruction presented
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_src1", out_src1, 32'd0);
        chk("rst_src2", out_src2, 32'd0);
        chk("rst_misc", {out_alu_fn, out_rd, out_funct3, act_flags(), out_pc[13:0]}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven single-cycle issue
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].inst, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d);
            #1 chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_fn", i), {28'd0, out_alu_fn}, {28'd0, vecs[i].fn});
            chk($sformatf("v%0d_src1", i), out_src1, vecs[i].src1);
            chk($sformatf("v%0d_src2", i), out_src2, vecs[i].src2);
            chk($sformatf("v%0d_rs2", i), out_rs2, vecs[i].rs2);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_f3", i), {29'd0, out_funct3}, {29'd0, vecs[i].f3});
            chk($sformatf("v%0d_flags", i), {26'd0, act_flags()}, {26'd0, vecs[i].flags});
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Load-use on rs1, then release
        drive(32'h00728333, 32'h200, 32'd3, 32'd4);
        ld_valid = 1'b1; ld_rd = 5'd5;
        #1 chk("lu_rs1_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("lu_rs1_bubble", {31'd0, out_valid}, 32'd0);
        ld_valid = 1'b0;
        #1 chk("lu_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("lu_release_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_release_src1", out_src1, 32'd3);
        chk("lu_release_src2", out_src2, 32'd4);
        // Load-use on rs2
        ld_valid = 1'b1; ld_rd = 5'd7;
        #1 chk("lu_rs2_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("lu_rs2_bubble", {31'd0, out_valid}, 32'd0);
        // Load to x0 never stalls
        ld_rd = 5'd0;
        #1 chk("lu_x0_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("lu_x0_valid", {31'd0, out_valid}, 32'd1);
        // LUI does not read rs1 even though its field matches the load
        drive(32'h123453B7, 32'h204, 32'd0, 32'd0);
        ld_rd = 5'd8;
        #1 chk("lu_lui_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("lu_lui_src2", out_src2, 32'h12345000);
        ld_valid = 1'b0; ld_rd = 5'd0;

        // Back-pressure: payload holds for 3 cycles, then the next one issues exactly once
        drive(32'hFFD08293, 32'h300, 32'd10, 32'd0);
        tick();
        out_ready = 1'b0;
        drive(32'h403100B3, 32'h304, 32'd100, 32'd30);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_src1", k), out_src1, 32'd10);
            chk($sformatf("bp%0d_pc", k), out_pc, 32'h300);
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_pc", out_pc, 32'h304);
        chk("bp_next_fn", {28'd0, out_alu_fn}, {28'd0, ALU_SUB});
        in_valid = 1'b0;
        tick();
        chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Flush kills the incoming instruction
        drive(32'hFFD08293, 32'h400, 32'd10, 32'd0);
        flush = 1'b1;
        #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        // Flush kills a held output
        tick();
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
        tick();
        chk("fl_held_valid", {31'd0, out_valid}, 32'd0);
        // Flush together with a hazard
        drive(32'h00728333, 32'h404, 32'd3, 32'd4);
        ld_valid = 1'b1; ld_rd = 5'd5; out_ready = 1'b1;
        #1 chk("fl_hz_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("fl_hz_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; ld_valid = 1'b0;

        // Reset while stalled discards the held payload
        drive(32'hFFD08293, 32'h500, 32'd10, 32'd0);
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall_src1", out_src1, 32'd0);
        rst = 1'b0; in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue pipeline stage that is the producer side of the ALU operand interface.
- Accepts fetched instructions over a valid/ready handshake and reads rs1/rs2 from the register file.
- Selects the `ALU_* function code and the src1/src2 operands.
- Presents the result registered to the EX stage one cycle later, with a load-use interlock, back-pressure and flush.

Parameters:
- DATA_LEN, 32, datapath width.
- ADDR_LEN, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the instruction being accepted and the held output
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  DATA_LEN  instruction PC
- rs1_addr  out  ADDR_LEN  regfile read address 1 = in_inst[19:15] (combinational)
- rs2_addr  out  ADDR_LEN  regfile read address 2 = in_inst[24:20] (combinational)
- rs1_data  in  DATA_LEN  same-cycle read data 1
- rs2_data  in  DATA_LEN  same-cycle read data 2
- ld_valid  in  1  downstream EX holds a load
- ld_rd  in  ADDR_LEN  destination of that load
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX accepts
- out_alu_fn  out  4  `ALU_* code
- out_src1  out  DATA_LEN  ALU operand 1
- out_src2  out  DATA_LEN  ALU operand 2
- out_rs2  out  DATA_LEN  store data
- out_pc  out  DATA_LEN  PC
- out_rd  out  ADDR_LEN  destination register
- out_funct3  out  3  branch/memory subtype
- out_wb_en  out  1  writes rd
- out_mem_ren  out  1  load
- out_mem_wen  out  1  store
- out_branch  out  1  conditional branch
- out_jump  out  1  JAL/JALR
- out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (rst=1 at a clk edge): out_valid and every out_* field become 0.
  - in_ready is combinational; with out_valid=0 and no hazard it is 1 in the first cycle after reset.
- Latency: exactly 1 cycle from accept (in_valid & in_ready) to out_valid=1.
  - The output register holds its payload stable while out_valid & !out_ready.
- Derived terms:
  - adv = !out_valid | out_ready
  - hazard = in_valid & ld_valid & (ld_rd!=0) & ((uses_rs1 & rs1_addr==ld_rd) | (uses_rs2 & rs2_addr==ld_rd))
  - in_ready = adv & !hazard & !flush
- Next-state, priority per clk edge:
  1. rst: clear.
  2. flush: out_valid<=0, input not captured.
  3. adv & hazard: bubble, out_valid<=0.
  4. adv & in_valid: capture decoded payload, out_valid<=1.
  5. adv & !in_valid: out_valid<=0.
  6. Otherwise hold.
- Register reads: address 0 yields operand 0 regardless of rs*_data.
  - No forwarding here; EX forwards.
- Operand/function selection:
  - OP (R-type): fn from funct3/funct7 (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND); src1=rs1, src2=rs2; wb_en=1.
  - OP-IMM: same mapping, funct7 only for SRAI/SRLI; src2=sign-extended imm_i (shift amount is in src2[4:0]); SUB never selected.
  - LUI: ADD, src1=0, src2=imm_u.
  - AUIPC: ADD, src1=pc, src2=imm_u.
  - JAL: ADD, src1=pc, src2=4, jump=1, wb_en=1 (link value).
  - JALR: ALU_JALR, src1=rs1, src2=imm_i, jump=1, wb_en=1; EX forms the link from out_pc+4.
  - BRANCH: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU; src1=rs1, src2=rs2, branch=1, wb_en=0.
  - LOAD: ADD, rs1+imm_i, mem_ren=1, wb_en=1.
  - STORE: ADD, rs1+imm_s, mem_wen=1, out_rs2=rs2.
  - Anything else: fn=ALU_X, illegal=1, wb_en/mem_*/branch/jump=0.
- rd=0 forces wb_en=0.
- uses_rs1 is 0 for LUI, AUIPC and JAL; uses_rs2 is 1 only for OP, BRANCH and STORE.
- Simultaneous flush and hazard: flush wins. Reset mid-stall: output cleared, stall state discarded.

Decomposition:
- define.vh: `ALU_* codes, opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE), funct3/funct7 constants.
- Sub-module inst_decoder: purely combinational (inst → fn, operand selects, immediates, control flags, uses_rs1/uses_rs2).
- id_issue_stage owns the handshake, hazard logic and output register.

Test Plan:
- Reset: rst=1 for 2 cycles → out_valid=0, all out_*=0; after release with in_valid=0 → in_ready=1.
- ADDI x5,x1,-3 with rs1_data=10 → next cycle out_valid=1, fn=ALU_ADD, src1=10, src2=0xFFFFFFFD, rd=5, wb_en=1.
- SRAI x2,x3,4 (0x4041D113) with rs1_data=0x80000000 → fn=ALU_SRA, src1=0x80000000, src2=0x00000404, rd=2.
- Load-use:
  - ld_valid=1, ld_rd=5, in_inst=ADD x6,x5,x7 → in_ready=0, next out_valid=0.
  - Then ld_valid=0 → accepted, out_valid=1.
  - Same case with ld_rd=0 → no stall.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles → payload stable, in_ready=0; then out_ready=1 → next instruction issued the following cycle, none lost or duplicated.
- Flush and illegal:
  - flush=1 with in_valid=1 → in_ready=0, next out_valid=0.
  - in_inst=0x0000007F → fn=ALU_X, illegal=1, wb_en=0.
